// File: rtl/pwm_spi_pkg.sv
// Shared constants and types for the PWM generator's SPI register front-end.
// Fixed mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes.
package pwm_spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);

  typedef logic [SPI_BYTE_W-1:0] spi_byte_t;
  typedef logic [SPI_CNT_W-1:0]  spi_cnt_t;

  localparam spi_byte_t TX_IDLE_DEFAULT = 8'h00;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Sample on rising sclk, shift on falling sclk, sclk idles low.
  localparam spi_mode_t SPI_MODE = '{cpol: 1'b0, cpha: 1'b0};

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchroniser with a configurable reset (idle) level.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  // NOTE: synchroniser flops reset to the pin's idle level so no false edge
  // is seen right after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= {STAGES{RST_VAL}};
    else        sync_ff <= {sync_ff[STAGES-2:0], d};
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 slave: synchronises the pins into clk, deserialises MOSI into
// bytes for the instruction decoder and serialises its response onto MISO.
module spi_bridge
  import pwm_spi_pkg::*;
#(
  parameter int        SYNC_STAGES = 2,
  parameter spi_byte_t TX_IDLE     = TX_IDLE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  byte_sync,
  output logic [SPI_BYTE_W-1:0] rx_data,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  output logic                  cs_active,
  output logic                  frame_end
);

  logic      sclk_s, cs_n_s, mosi_s;
  logic      sclk_q, cs_n_q;
  logic      edge_en, sclk_rise, sclk_fall, cs_fall, cs_rise, byte_done;
  logic      cap_pend;
  spi_cnt_t  bit_cnt;
  spi_byte_t rx_shift, tx_shift;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
  );

  // Edges still count in the cycle cs_n rises, so an 8th rising sclk that
  // lands together with the cs_n rise still completes its byte.
  assign edge_en   = ~cs_n_s | ~cs_n_q;
  assign sclk_rise = edge_en &  sclk_s & ~sclk_q;
  assign sclk_fall = edge_en & ~sclk_s &  sclk_q;
  assign cs_fall   =  cs_n_q & ~cs_n_s;
  assign cs_rise   = ~cs_n_q &  cs_n_s;
  assign byte_done = sclk_rise && (bit_cnt == spi_cnt_t'(SPI_BYTE_W - 1));

  assign cs_active = ~cs_n_s;
  assign miso      = cs_active & tx_shift[SPI_BYTE_W-1];

  // NOTE: all state updates use non-blocking assignments so every branch
  // below sees the pre-edge values of bit_cnt and the shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      byte_sync <= 1'b0;
      frame_end <= 1'b0;
      cap_pend  <= 1'b0;
    end else begin
      sclk_q    <= sclk_s;
      cs_n_q    <= cs_n_s;
      byte_sync <= byte_done;
      frame_end <= cs_rise;
      cap_pend  <= byte_sync;

      if (sclk_rise) begin
        rx_shift <= {rx_shift[SPI_BYTE_W-2:0], mosi_s};
        bit_cnt  <= bit_cnt + spi_cnt_t'(1);
      end
      if (byte_done) rx_data <= {rx_shift[SPI_BYTE_W-2:0], mosi_s};
      // A partial byte at frame end is dropped by restarting the count.
      if (cs_fall || cs_rise) bit_cnt <= '0;

      // Capture lands one cycle after byte_sync, before the next falling sclk;
      // the falling edge that follows the 8th rising edge must not shift.
      if (cs_fall)
        tx_shift <= TX_IDLE;
      else if (cap_pend)
        tx_shift <= tx_data;
      else if (sclk_fall && bit_cnt != '0)
        tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_bridge.sv
// Directed bench for spi_bridge: an SPI master model drives frames while a
// scoreboard queue of expected bytes is checked by an independent monitor.
module tb_spi_bridge;

  localparam int  CLK_P = 10;
  localparam int  HALF  = 8 * CLK_P;   // fsclk = fclk/16
  localparam int  SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst_n, sclk, cs_n, mosi;
  logic       miso, byte_sync, cs_active, frame_end;
  logic [7:0] rx_data, tx_data;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         bs_cnt   = 0;
  int         fe_cnt   = 0;
  int         fe_exp   = 0;
  logic [7:0] tx_next  = 8'h00;
  logic       bs_prev  = 1'b0;
  logic [7:0] exp_q[$];
  int         bs_times[$];

  spi_bridge #(.SYNC_STAGES(SYNC), .TX_IDLE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .byte_sync(byte_sync), .rx_data(rx_data), .tx_data(tx_data),
    .cs_active(cs_active), .frame_end(frame_end)
  );

  always #(CLK_P/2) clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every byte_sync pops the next expected byte.
  always @(negedge clk) begin
    if (byte_sync) begin
      bs_cnt++;
      bs_times.push_back(cyc);
      check("byte_sync_width", 32'(bs_prev), 32'd0);
      if (exp_q.size() == 0) check("unexpected_byte_sync", 32'(rx_data), 32'hFFFF_FFFF);
      else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    if (frame_end) fe_cnt++;
    bs_prev = byte_sync;
  end

  // Decoder model: present the response byte during cycle N+1.
  initial begin
    tx_data = 8'hEE;
    forever begin
      @(negedge clk);
      if (byte_sync) begin
        @(posedge clk);
        #1 tx_data = tx_next;
      end
    end
  end

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    #HALF;
    sclk = 1'b1;
    r    = miso;
    #HALF;
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] d, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) spi_bit(d[i], r[i]);
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    #(6*CLK_P);
  endtask

  task automatic frame_finish();
    #HALF;
    cs_n = 1'b1;
    fe_exp++;
    #(8*CLK_P);
    check("frame_end_count", 32'(fe_cnt), 32'(fe_exp));
    check("miso_idle", 32'(miso), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_sync"}, 32'(byte_sync), 32'd0);
    check({tag, "_rx_data"},   32'(rx_data),   32'd0);
    check({tag, "_miso"},      32'(miso),      32'd0);
    check({tag, "_cs_active"}, 32'(cs_active), 32'd0);
    check({tag, "_frame_end"}, 32'(frame_end), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rb;
    int         bs_base;

    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    #3;

    // 1: reset holds everything idle even with cs_n low and sclk toggling
    cs_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #(4*CLK_P) sclk = ~sclk; mosi = ~mosi;
    end
    sclk = 1'b0; mosi = 1'b0;
    #(4*CLK_P);
    check_reset_outputs("rst");
    check("rst_bs_cnt", 32'(bs_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1 check("cs_active_after_release", 32'(cs_active), 32'd1);
    #(4*CLK_P);
    frame_finish();

    // 2: single byte 0xA5, slave answers TX_IDLE
    exp_q.push_back(8'hA5);
    frame_begin();
    spi_byte(8'hA5, rd);
    check("t2_miso", 32'(rd), 32'h00);
    frame_finish();
    check("t2_bs_cnt", 32'(bs_cnt), 32'd1);

    // 3: two bytes, decoder responds 0x3C to the first
    tx_next = 8'h3C;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hC3);
    frame_begin();
    spi_byte(8'h12, rd);
    check("t3_miso_b0", 32'(rd), 32'h00);
    spi_byte(8'hC3, rd);
    check("t3_miso_b1", 32'(rd), 32'h3C);
    frame_finish();
    check("t3_bs_cnt", 32'(bs_cnt), 32'd3);

    // 4: three back-to-back bytes, pulses 8 sclk periods apart
    tx_next = 8'h96;
    bs_times.delete();
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    frame_begin();
    spi_byte(8'h80, rd);
    check("t4_miso_b0", 32'(rd), 32'h00);
    spi_byte(8'h01, rd);
    check("t4_miso_b1", 32'(rd), 32'h96);
    spi_byte(8'hFF, rd);
    check("t4_miso_b2", 32'(rd), 32'h96);
    frame_finish();
    check("t4_pulses", 32'(bs_times.size()), 32'd3);
    if (bs_times.size() == 3) begin
      check("t4_gap01", 32'(bs_times[1] - bs_times[0]), 32'd128);
      check("t4_gap12", 32'(bs_times[2] - bs_times[1]), 32'd128);
    end

    // 5: partial byte (5 bits of 0xF0) is discarded
    bs_base = bs_cnt;
    frame_begin();
    for (int i = 7; i >= 3; i--) spi_bit(1'((8'hF0 >> i) & 8'h01), rb);
    frame_finish();
    check("t5_no_byte_sync", 32'(bs_cnt), 32'(bs_base));
    check("t5_rx_hold", 32'(rx_data), 32'hFF);
    exp_q.push_back(8'h81);
    frame_begin();
    spi_byte(8'h81, rd);
    frame_finish();
    check("t5_rx_next", 32'(rx_data), 32'h81);

    // 6: reset mid-byte, then a clean frame
    frame_begin();
    for (int i = 7; i >= 5; i--) spi_bit(1'((8'hE7 >> i) & 8'h01), rb);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    #(3*CLK_P) rst_n = 1'b1;
    #(6*CLK_P);
    check("midrst_no_frame_end", 32'(fe_cnt), 32'(fe_exp));
    bs_base = bs_cnt;
    exp_q.push_back(8'h5A);
    frame_begin();
    spi_byte(8'h5A, rd);
    frame_finish();
    check("t6_bs_cnt", 32'(bs_cnt), 32'(bs_base + 1));
    check("t6_rx", 32'(rx_data), 32'h5A);

    // drain: all expected bytes must have been observed
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
